// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle control unit: state encoding,
// opcode map and instruction field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_e;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_SHIFT = 4'h5;
  localparam logic [3:0] OP_LDI   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_BZ    = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS_LSB  = 6;
  localparam int RT_LSB  = 3;
  localparam int IMM9_W  = 9;
  localparam int IMM12_W = 12;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Fetch port, register-file controls and ALU mux hookup between the control
// unit (master) and its datapath/memory environment (slave).
interface cpu_control_fsm_if #(parameter int PC_W = 12);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     instr;
  logic [2:0]      rf_raddr_a;
  logic [2:0]      rf_raddr_b;
  logic [2:0]      alu_sel;
  logic [15:0]     alu_result;
  logic            rf_we;
  logic [2:0]      rf_waddr;
  logic            rf_wsel;
  logic [15:0]     imm_out;
  logic            zero_flag;
  logic            halted;
  logic            run;

  modport master (
    output imem_req, imem_addr, rf_raddr_a, rf_raddr_b, alu_sel, rf_we,
           rf_waddr, rf_wsel, imm_out, zero_flag, halted,
    input  imem_ack, instr, alu_result, run
  );

  modport slave (
    input  imem_req, imem_addr, rf_raddr_a, rf_raddr_b, alu_sel, rf_we,
           rf_waddr, rf_wsel, imm_out, zero_flag, halted,
    output imem_ack, instr, alu_result, run
  );
endinterface

// File: rtl/instr_decoder.sv
// Purely combinational IR decode: register addresses, mux select, immediates
// and instruction class flags.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0]        i_ir,
  output logic [2:0]         o_alu_sel,
  output logic [2:0]         o_raddr_a,
  output logic [2:0]         o_raddr_b,
  output logic [2:0]         o_waddr,
  output logic [15:0]        o_imm,
  output logic [IMM12_W-1:0] o_imm12,
  output logic               o_is_alu,
  output logic               o_is_ldi,
  output logic               o_is_jmp,
  output logic               o_is_bz,
  output logic               o_is_halt
);
  logic [3:0] w_op;

  always_comb begin
    w_op      = i_ir[OPC_LSB +: 4];
    o_is_alu  = (w_op <= OP_SHIFT);
    o_is_ldi  = (w_op == OP_LDI);
    o_is_jmp  = (w_op == OP_JMP);
    o_is_bz   = (w_op == OP_BZ);
    o_is_halt = (w_op == OP_HALT);
    // Non-ALU opcodes park the mux on input 0 so the select never wanders.
    o_alu_sel = o_is_alu ? w_op[2:0] : 3'd0;
    o_raddr_a = i_ir[RS_LSB +: 3];
    o_raddr_b = i_ir[RT_LSB +: 3];
    o_waddr   = i_ir[RD_LSB +: 3];
    o_imm     = {{(16-IMM9_W){1'b0}}, i_ir[IMM9_W-1:0]};
    o_imm12   = i_ir[IMM12_W-1:0];
  end
endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with HALT; owns pc, IR
// and the zero flag. All outputs come from state and IR only.
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int          PC_W     = 12,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_control_fsm_if.master  bus
);
  state_e              r_state, w_next;
  logic [PC_W-1:0]     r_pc;
  logic [15:0]         r_ir;
  logic                r_zf;

  logic [2:0]          w_alu_sel, w_raddr_a, w_raddr_b, w_waddr;
  logic [15:0]         w_imm;
  logic [IMM12_W-1:0]  w_imm12;
  logic                w_is_alu, w_is_ldi, w_is_jmp, w_is_bz, w_is_halt;

  instr_decoder u_dec (
    .i_ir      (r_ir),
    .o_alu_sel (w_alu_sel),
    .o_raddr_a (w_raddr_a),
    .o_raddr_b (w_raddr_b),
    .o_waddr   (w_waddr),
    .o_imm     (w_imm),
    .o_imm12   (w_imm12),
    .o_is_alu  (w_is_alu),
    .o_is_ldi  (w_is_ldi),
    .o_is_jmp  (w_is_jmp),
    .o_is_bz   (w_is_bz),
    .o_is_halt (w_is_halt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:     if (bus.imem_ack) w_next = DECODE;
      DECODE:    w_next = EXECUTE;
      EXECUTE:   w_next = WRITEBACK;
      WRITEBACK: w_next = w_is_halt ? HALT : FETCH;
      HALT:      if (bus.run) w_next = FETCH;
      default:   w_next = FETCH;
    endcase
  end

  // pc moves exactly once per instruction (in WRITEBACK) or once on resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_W'(RESET_PC);
      r_ir <= '0;
      r_zf <= 1'b0;
    end else begin
      if (r_state == FETCH && bus.imem_ack) r_ir <= bus.instr;
      if (r_state == WRITEBACK) begin
        if (w_is_alu) r_zf <= (bus.alu_result == 16'h0);
        if (w_is_jmp || (w_is_bz && r_zf)) r_pc <= w_imm12[PC_W-1:0];
        else if (!w_is_halt)               r_pc <= r_pc + PC_W'(1);
      end
      if (r_state == HALT && bus.run) r_pc <= r_pc + PC_W'(1);
    end
  end

  always_comb begin
    bus.imem_req   = (r_state == FETCH);
    bus.imem_addr  = r_pc;
    bus.rf_raddr_a = w_raddr_a;
    bus.rf_raddr_b = w_raddr_b;
    bus.alu_sel    = w_alu_sel;
    bus.imm_out    = w_imm;
    bus.rf_waddr   = w_waddr;
    bus.rf_wsel    = w_is_ldi;
    bus.rf_we      = (r_state == WRITEBACK) && (w_is_alu || w_is_ldi);
    bus.zero_flag  = r_zf;
    bus.halted     = (r_state == HALT);
  end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Instruction-level reference model driving random and directed programs
// through the control unit and checking every phase of each instruction.
module tb_cpu_control_fsm;
  localparam int PC_W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_control_fsm_if #(.PC_W(PC_W)) bus();

  cpu_control_fsm #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [PC_W-1:0] m_pc;
  logic            m_zf;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One instruction: fetch with dly wait cycles, then decode/execute/writeback.
  task automatic run_instr(input logic [15:0] ins, input int dly, input logic [15:0] res);
    logic [3:0] op;
    bit is_alu, is_ldi;
    op = ins[15:12];
    is_alu = (op <= 4'd5);
    is_ldi = (op == 4'd6);
    bus.alu_result = 16'($urandom);
    for (int w = 0; w <= dly; w++) begin
      bus.imem_ack = (w == dly);
      bus.instr = (w == dly) ? ins : 16'($urandom);
      n_chk++;
      if ({bus.imem_req, bus.imem_addr, bus.rf_we, bus.halted, bus.zero_flag} !== {1'b1, m_pc, 1'b0, 1'b0, m_zf}) begin
        n_fail++;
        $display("FAIL fetch(req,addr,we,halt,zf) ins=%h w=%0d: got %h exp %h", ins, w,
          {bus.imem_req, bus.imem_addr, bus.rf_we, bus.halted, bus.zero_flag}, {1'b1, m_pc, 1'b0, 1'b0, m_zf});
      end
      step();
    end
    // Decode: spurious acks and garbage on instr must be ignored from here on.
    bus.imem_ack = 1'($urandom);
    bus.instr = 16'($urandom);
    bus.alu_result = res;
    n_chk++;
    if ({bus.imem_req, bus.rf_we, bus.rf_raddr_a, bus.rf_raddr_b, bus.imm_out} !== {1'b0, 1'b0, ins[8:6], ins[5:3], {7'b0, ins[8:0]}}) begin
      n_fail++;
      $display("FAIL decode(req,we,ra,rb,imm) ins=%h: got %h exp %h", ins,
        {bus.imem_req, bus.rf_we, bus.rf_raddr_a, bus.rf_raddr_b, bus.imm_out}, {1'b0, 1'b0, ins[8:6], ins[5:3], {7'b0, ins[8:0]}});
    end
    if (is_alu) begin
      n_chk++;
      if (bus.alu_sel !== op[2:0]) begin
        n_fail++;
        $display("FAIL alu_sel ins=%h: got %0d exp %0d", ins, bus.alu_sel, op[2:0]);
      end
    end
    step();
    n_chk++;
    if ({bus.imem_req, bus.rf_we, bus.halted, bus.rf_raddr_a, bus.rf_raddr_b} !== {3'b000, ins[8:6], ins[5:3]}) begin
      n_fail++;
      $display("FAIL execute(req,we,halt,ra,rb) ins=%h: got %h exp %h", ins,
        {bus.imem_req, bus.rf_we, bus.halted, bus.rf_raddr_a, bus.rf_raddr_b}, {3'b000, ins[8:6], ins[5:3]});
    end
    step();
    n_chk++;
    if ({bus.imem_req, bus.rf_we} !== {1'b0, 1'(is_alu || is_ldi)}) begin
      n_fail++;
      $display("FAIL writeback(req,we) ins=%h: got %b exp %b", ins, {bus.imem_req, bus.rf_we}, {1'b0, 1'(is_alu || is_ldi)});
    end
    if (is_alu || is_ldi) begin
      n_chk++;
      if ({bus.rf_waddr, bus.rf_wsel} !== {ins[11:9], 1'(is_ldi)}) begin
        n_fail++;
        $display("FAIL writeback(waddr,wsel) ins=%h: got %h exp %h", ins, {bus.rf_waddr, bus.rf_wsel}, {ins[11:9], 1'(is_ldi)});
      end
    end
    step();
    bus.imem_ack = 1'b0;
    if (is_alu) m_zf = (res == 16'h0);
    case (op)
      4'h7:    m_pc = ins[PC_W-1:0];
      4'h8:    m_pc = m_zf ? ins[PC_W-1:0] : m_pc + PC_W'(1);
      4'hF:    ;
      default: m_pc = m_pc + PC_W'(1);
    endcase
  endtask

  // Sit in HALT for n cycles, then pulse run and expect fetch at pc+1.
  task automatic halt_wait(input int n);
    for (int i = 0; i < n; i++) begin
      bus.run = 1'b0;
      bus.imem_ack = 1'($urandom);
      n_chk++;
      if ({bus.halted, bus.imem_req, bus.rf_we} !== 3'b100) begin
        n_fail++;
        $display("FAIL halt(halted,req,we) cycle %0d: got %b exp 100", i, {bus.halted, bus.imem_req, bus.rf_we});
      end
      step();
    end
    bus.imem_ack = 1'b0;
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    m_pc = m_pc + PC_W'(1);
    n_chk++;
    if ({bus.halted, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, m_pc}) begin
      n_fail++;
      $display("FAIL resume(halted,req,addr): got %h exp %h", {bus.halted, bus.imem_req, bus.imem_addr}, {1'b0, 1'b1, m_pc});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.instr = 16'h0;
    bus.alu_result = 16'h0;
    bus.run = 1'b0;
    #12;
    n_chk++;
    if ({bus.imem_req, bus.imem_addr, bus.rf_we, bus.alu_sel, bus.rf_wsel, bus.imm_out, bus.halted, bus.zero_flag}
        !== {1'b1, 12'h000, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h exp %h",
        {bus.imem_req, bus.imem_addr, bus.rf_we, bus.alu_sel, bus.rf_wsel, bus.imm_out, bus.halted, bus.zero_flag},
        {1'b1, 12'h000, 1'b0, 3'd0, 1'b0, 16'h0, 1'b0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    m_pc = '0;
    m_zf = 1'b0;
  endtask

  task automatic test_alu_ldi_bz();
    run_instr(16'h0298, 0, 16'h1234);   // ADD r1 = r2 + r3 at pc 0
    run_instr(16'h6A55, 0, 16'h0000);   // LDI r5, zero flag must stay clear
    run_instr(16'h1000, 0, 16'h0000);   // SUB -> zero
    run_instr(16'h8040, 0, 16'h5555);   // BZ taken -> 0x040
    n_chk++;
    if (bus.imem_addr !== 12'h040) begin
      n_fail++;
      $display("FAIL bz_taken: got %h exp 040", bus.imem_addr);
    end
    run_instr(16'h1000, 0, 16'h0001);   // SUB -> nonzero
    run_instr(16'h8040, 0, 16'h0000);   // BZ not taken -> 0x042
    n_chk++;
    if (bus.imem_addr !== 12'h042) begin
      n_fail++;
      $display("FAIL bz_not_taken: got %h exp 042", bus.imem_addr);
    end
  endtask

  task automatic test_ack_delay();
    run_instr(16'h2AC8, 3, 16'h00F0);
    run_instr(16'h4E3F, 1, 16'h0000);
  endtask

  task automatic test_halt();
    run_instr(16'h7007, 0, 16'h0000);   // JMP 7
    run_instr(16'hF000, 0, 16'h0000);
    halt_wait(10);
  endtask

  task automatic test_wrap();
    run_instr(16'h7FFF, 0, 16'h0000);
    run_instr(16'h9000, 0, 16'h0000);
    n_chk++;
    if (bus.imem_addr !== 12'h000) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h exp 000", bus.imem_addr);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      logic [15:0] ins, res;
      ins = 16'($urandom);
      res = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      run_instr(ins, int'($urandom_range(0, 3)), res);
      if (ins[15:12] == 4'hF) halt_wait(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_execute();
    run_instr(16'h7123, 0, 16'h0000);
    bus.imem_ack = 1'b1;
    bus.instr = 16'h0298;
    step();                              // now in DECODE
    bus.imem_ack = 1'b0;
    bus.alu_result = 16'h0000;
    step();                              // now in EXECUTE
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({bus.rf_we, bus.imem_req, bus.imem_addr, bus.halted, bus.zero_flag} !== {1'b0, 1'b1, 12'h000, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid_exec(we,req,addr,halt,zf) cycle %0d: got %h exp %h", i,
          {bus.rf_we, bus.imem_req, bus.imem_addr, bus.halted, bus.zero_flag}, {1'b0, 1'b1, 12'h000, 1'b0, 1'b0});
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    m_pc = '0;
    m_zf = 1'b0;
    run_instr(16'h0298, 0, 16'h0000);
    run_instr(16'h9000, 2, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_alu_ldi_bz();
    test_ack_delay();
    test_halt();
    test_wrap();
    test_random();
    test_reset_mid_execute();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
